// File: rtl/lrb_alpha_finder_pkg.sv
// Shared constants and FSM encoding for the least-reliable-bit alpha finder.
package lrb_alpha_finder_pkg;

    localparam int LRB_GF_LEN    = 10;
    localparam int LRB_PRIM_POLY = 'h409;   // x^10 + x^3 + 1
    localparam int LRB_RELI_LEN  = 4;
    localparam int LRB_CODE_LEN  = 1023;
    localparam int LRB_CNT_LEN   = 10;
    localparam int LRB_NUM_SLOTS = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } lrb_state_e;

endpackage

// File: rtl/lrb_alpha_finder_gf_mul.sv
// Multiply a GF(2^GF_LEN) element by alpha: shift left, reduce by the
// primitive polynomial when the old MSB falls out.
module gf_mul_by_alpha #(
    parameter int GF_LEN    = 10,
    parameter int PRIM_POLY = 'h409
) (
    input  logic [GF_LEN-1:0] a_i,
    output logic [GF_LEN-1:0] y_o
);

    // Only the low GF_LEN bits matter; x^GF_LEN is the bit being shifted out.
    localparam logic [GF_LEN-1:0] POLY_LOW = GF_LEN'(PRIM_POLY);

    assign y_o = {a_i[GF_LEN-2:0], 1'b0} ^ (a_i[GF_LEN-1] ? POLY_LOW : '0);

endmodule

// File: rtl/lrb_alpha_finder.sv
// Scans a codeword one bit per cycle, keeps the three least-reliable bits in a
// sorted table and reports their positions as alpha^pos.
module lrb_alpha_finder
    import lrb_alpha_finder_pkg::*;
#(
    parameter int GF_LEN    = LRB_GF_LEN,
    parameter int PRIM_POLY = LRB_PRIM_POLY,
    parameter int RELI_LEN  = LRB_RELI_LEN,
    parameter int CODE_LEN  = LRB_CODE_LEN,
    parameter int CNT_LEN   = LRB_CNT_LEN
) (
    input  logic                clk,
    input  logic                in_ctr_Arst_n,
    input  logic                in_ctr_init,
    input  logic                in_ctr_en,
    input  logic                in_ctr_last,
    input  logic [RELI_LEN-1:0] in_reli,
    output logic [GF_LEN-1:0]   out_alpha1,
    output logic [GF_LEN-1:0]   out_alpha2,
    output logic [GF_LEN-1:0]   out_alpha3,
    output logic                out_valid,
    output logic                out_err
);

    localparam int NSLOT = LRB_NUM_SLOTS;
    localparam logic [GF_LEN-1:0]  ALPHA_ONE = GF_LEN'(1);
    localparam logic [CNT_LEN-1:0] CNT_LAST  = CNT_LEN'(CODE_LEN - 1);

    lrb_state_e          state_q, state_d;
    logic [GF_LEN-1:0]   pos_q, pos_d;
    logic [CNT_LEN-1:0]  cnt_q, cnt_d;
    logic [RELI_LEN-1:0] slot_reli_q  [NSLOT];
    logic [RELI_LEN-1:0] slot_reli_d  [NSLOT];
    logic [GF_LEN-1:0]   slot_alpha_q [NSLOT];
    logic [GF_LEN-1:0]   slot_alpha_d [NSLOT];
    logic [NSLOT-1:0]    slot_vld_q, slot_vld_d;
    logic [GF_LEN-1:0]   out_alpha_q  [NSLOT];
    logic [GF_LEN-1:0]   out_alpha_d  [NSLOT];
    logic                out_valid_q, out_valid_d;
    logic                out_err_q, out_err_d;

    // Table/counter view after an optional init in this cycle.
    logic [RELI_LEN-1:0] base_reli  [NSLOT];
    logic [GF_LEN-1:0]   base_alpha [NSLOT];
    logic [NSLOT-1:0]    base_vld;
    logic [CNT_LEN-1:0]  base_cnt;
    logic [GF_LEN-1:0]   cur_alpha;
    logic [GF_LEN-1:0]   next_alpha;
    logic [NSLOT-1:0]    lt;
    logic                accept;
    logic                overflow;

    // A bit arriving together with init is position 0, i.e. alpha^0.
    assign cur_alpha = in_ctr_init ? ALPHA_ONE : pos_q;
    assign accept    = in_ctr_en && (in_ctr_init || (state_q == ST_COLLECT));
    assign overflow  = (base_cnt == CNT_LAST);

    gf_mul_by_alpha #(
        .GF_LEN   (GF_LEN),
        .PRIM_POLY(PRIM_POLY)
    ) u_step (
        .a_i(cur_alpha),
        .y_o(next_alpha)
    );

    // Clear the table view on init so the same-cycle bit sees an empty table.
    always_comb begin
        base_cnt = in_ctr_init ? '0 : cnt_q;
        base_vld = in_ctr_init ? '0 : slot_vld_q;
        for (int i = 0; i < NSLOT; i++) begin
            base_reli[i]  = in_ctr_init ? '1 : slot_reli_q[i];
            base_alpha[i] = in_ctr_init ? '0 : slot_alpha_q[i];
        end
    end

    // Next-state, sorted insertion and output update.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        cnt_d       = base_cnt;
        slot_vld_d  = base_vld;
        out_valid_d = 1'b0;
        out_err_d   = out_err_q;
        lt          = '0;
        for (int i = 0; i < NSLOT; i++) begin
            slot_reli_d[i]  = base_reli[i];
            slot_alpha_d[i] = base_alpha[i];
            out_alpha_d[i]  = out_alpha_q[i];
        end

        if (in_ctr_init) begin
            state_d   = ST_COLLECT;
            pos_d     = ALPHA_ONE;
            out_err_d = 1'b0;
            for (int i = 0; i < NSLOT; i++) out_alpha_d[i] = '0;
        end

        if (accept) begin
            // Strict less-than keeps the earlier position ahead on ties.
            for (int i = 0; i < NSLOT; i++)
                lt[i] = !base_vld[i] || (in_reli < base_reli[i]);

            if (lt[0]) begin
                slot_reli_d[0]  = in_reli;
                slot_alpha_d[0] = cur_alpha;
                slot_vld_d[0]   = 1'b1;
            end
            for (int i = 1; i < NSLOT; i++) begin
                if (lt[i-1]) begin
                    slot_reli_d[i]  = base_reli[i-1];
                    slot_alpha_d[i] = base_alpha[i-1];
                    slot_vld_d[i]   = base_vld[i-1];
                end else if (lt[i]) begin
                    slot_reli_d[i]  = in_reli;
                    slot_alpha_d[i] = cur_alpha;
                    slot_vld_d[i]   = 1'b1;
                end
            end

            pos_d = next_alpha;
            cnt_d = base_cnt + CNT_LEN'(1);

            if (in_ctr_last || overflow) begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                for (int i = 0; i < NSLOT; i++) out_alpha_d[i] = slot_alpha_d[i];
                if (!in_ctr_last) out_err_d = 1'b1;
            end
        end
    end

    // State and table registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            state_q     <= ST_IDLE;
            pos_q       <= ALPHA_ONE;
            cnt_q       <= '0;
            slot_vld_q  <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                slot_reli_q[i]  <= '1;
                slot_alpha_q[i] <= '0;
                out_alpha_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            cnt_q       <= cnt_d;
            slot_vld_q  <= slot_vld_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            for (int i = 0; i < NSLOT; i++) begin
                slot_reli_q[i]  <= slot_reli_d[i];
                slot_alpha_q[i] <= slot_alpha_d[i];
                out_alpha_q[i]  <= out_alpha_d[i];
            end
        end
    end

    assign out_alpha1 = out_alpha_q[0];
    assign out_alpha2 = out_alpha_q[1];
    assign out_alpha3 = out_alpha_q[2];
    assign out_valid  = out_valid_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_lrb_alpha_finder.sv
// Directed bench: a table of frames with hand-computed alphas, plus sequences
// for reset, overflow and mid-frame abort. Two instances share the stimulus:
// one at the full frame length, one with a 16-bit frame limit.
module tb_lrb_alpha_finder;

    logic       clk;
    logic       rst_n;
    logic       init;
    logic       en;
    logic       last;
    logic [3:0] reli;

    logic [9:0] a1_s, a2_s, a3_s, a1_o, a2_o, a3_o;
    logic       valid_s, err_s, valid_o, err_o;

    int checks   = 0;
    int failures = 0;

    lrb_alpha_finder dut_std (
        .clk          (clk),
        .in_ctr_Arst_n(rst_n),
        .in_ctr_init  (init),
        .in_ctr_en    (en),
        .in_ctr_last  (last),
        .in_reli      (reli),
        .out_alpha1   (a1_s),
        .out_alpha2   (a2_s),
        .out_alpha3   (a3_s),
        .out_valid    (valid_s),
        .out_err      (err_s)
    );

    lrb_alpha_finder #(.CODE_LEN(16), .CNT_LEN(5)) dut_ovf (
        .clk          (clk),
        .in_ctr_Arst_n(rst_n),
        .in_ctr_init  (init),
        .in_ctr_en    (en),
        .in_ctr_last  (last),
        .in_reli      (reli),
        .out_alpha1   (a1_o),
        .out_alpha2   (a2_o),
        .out_alpha3   (a3_o),
        .out_valid    (valid_o),
        .out_err      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        int               nbits;
        bit               init_with_first;
        logic [11:0][3:0] reli;     // reli[k] is bit k
        logic [9:0]       exp_a1;
        logic [9:0]       exp_a2;
        logic [9:0]       exp_a3;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drive one frame from the table; inputs change on the falling edge.
    task automatic send_frame(input int idx);
        @(negedge clk);
        if (!vecs[idx].init_with_first) begin
            init = 1'b1; en = 1'b0; last = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < vecs[idx].nbits; k++) begin
            init = vecs[idx].init_with_first && (k == 0);
            en   = 1'b1;
            reli = vecs[idx].reli[k];
            last = (k == vecs[idx].nbits - 1);
            @(negedge clk);
        end
        init = 1'b0; en = 1'b0; last = 1'b0;
    endtask

    task automatic check_frame(input int idx);
        string n;
        n = vecs[idx].name;
        chk({n, "_std_valid"}, {31'd0, valid_s}, 32'd1);
        chk({n, "_std_a1"}, {22'd0, a1_s}, {22'd0, vecs[idx].exp_a1});
        chk({n, "_std_a2"}, {22'd0, a2_s}, {22'd0, vecs[idx].exp_a2});
        chk({n, "_std_a3"}, {22'd0, a3_s}, {22'd0, vecs[idx].exp_a3});
        chk({n, "_std_err"}, {31'd0, err_s}, 32'd0);
        chk({n, "_ovf_valid"}, {31'd0, valid_o}, 32'd1);
        chk({n, "_ovf_a1"}, {22'd0, a1_o}, {22'd0, vecs[idx].exp_a1});
        $display("frame %s: alpha=%03h %03h %03h valid=%0d", n, a1_s, a2_s, a3_s, valid_s);
        // out_valid is a single-cycle pulse; alphas hold afterwards.
        @(negedge clk);
        chk({n, "_std_valid_drop"}, {31'd0, valid_s}, 32'd0);
        chk({n, "_std_a1_hold"}, {22'd0, a1_s}, {22'd0, vecs[idx].exp_a1});
    endtask

    initial begin
        vecs[0] = '{"basic", 8, 1'b0, 48'h0000_6825_1937, 10'h008, 10'h020, 10'h002};
        vecs[1] = '{"ties",  6, 1'b0, 48'h0000_0044_4444, 10'h001, 10'h002, 10'h004};
        vecs[2] = '{"wrap", 12, 1'b0, 48'h102F_FFFF_FFFF, 10'h009, 10'h012, 10'h200};
        vecs[3] = '{"short", 2, 1'b1, 48'h0000_0000_0035, 10'h002, 10'h001, 10'h000};

        rst_n = 1'b1; init = 1'b0; en = 1'b0; last = 1'b0; reli = 4'd0;

        // Reset asserted before any clock edge must clear outputs on its own.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_a1", {22'd0, a1_s}, 32'd0);
        chk("rst_async_valid", {31'd0, valid_s}, 32'd0);
        chk("rst_async_err", {31'd0, err_s}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            send_frame(v);
            check_frame(v);
        end

        // Overflow on the 16-bit instance: the 16th bit still enters the table.
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        for (int k = 0; k < 16; k++) begin
            en   = 1'b1;
            reli = (k == 13) ? 4'd2 : (k == 14) ? 4'd1 : (k == 15) ? 4'd0 : 4'd15;
            @(negedge clk);
        end
        chk("ovf_valid", {31'd0, valid_o}, 32'd1);
        chk("ovf_err", {31'd0, err_o}, 32'd1);
        chk("ovf_a1", {22'd0, a1_o}, 32'h120);
        chk("ovf_a2", {22'd0, a2_o}, 32'h090);
        chk("ovf_a3", {22'd0, a3_o}, 32'h048);
        chk("ovf_std_no_valid", {31'd0, valid_s}, 32'd0);
        chk("ovf_std_no_err", {31'd0, err_s}, 32'd0);
        $display("frame overflow: alpha=%03h %03h %03h err=%0d", a1_o, a2_o, a3_o, err_o);
        // Bits after DONE are ignored; error stays sticky.
        reli = 4'd0;
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        chk("ovf_done_no_valid", {31'd0, valid_o}, 32'd0);
        chk("ovf_err_sticky", {31'd0, err_o}, 32'd1);
        chk("ovf_a1_hold", {22'd0, a1_o}, 32'h120);

        // Async reset mid-cycle clears outputs with no clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_a1", {22'd0, a1_o}, 32'd0);
        chk("rst_mid_err", {31'd0, err_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort: reset during a frame, then later bits must not produce a result.
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en = 1'b1; reli = 4'd0;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1; reli = 4'd0; last = 1'b1;
        @(negedge clk);
        en = 1'b0; last = 1'b0;
        chk("abort_no_valid", {31'd0, valid_s}, 32'd0);
        chk("abort_a1_zero", {22'd0, a1_s}, 32'd0);
        $display("frame abort: valid=%0d alpha1=%03h", valid_s, a1_s);

        // The next frame after the abort is correct.
        send_frame(0);
        check_frame(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
